output_mems: RTL and testbench
==============================

OUTPUT_MEMS -- requirements
Module: output_mems

Interface
REQ-001 SHALL have parameter OUTW, default 24, width of one result word.
REQ-002 SHALL have parameter M, default 7, result rows.
REQ-003 SHALL have parameter N, default 9, result columns.
REQ-004 SHALL derive localparam C_ADDR_BITS = $clog2(M*N).
REQ-005 SHALL have port clk  input  1  clock; all logic on posedge.
REQ-006 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-007 SHALL have port C_wr_en  input  1  compute-side write strobe.
REQ-008 SHALL have port C_wr_addr  input  C_ADDR_BITS  write address, row-major (row*N+col).
REQ-009 SHALL have port C_wr_data  input  OUTW  signed result word.
REQ-010 SHALL have port compute_finished  input  1  one-cycle pulse: all M*N results written.
REQ-011 SHALL have port output_ready  output  1  high while the buffer accepts compute writes.
REQ-012 SHALL have port AXIS_TDATA  output  OUTW  streamed result word.
REQ-013 SHALL have port AXIS_TVALID  output  1  master valid.
REQ-014 SHALL have port AXIS_TREADY  input  1  downstream ready.
REQ-015 SHALL have port AXIS_TLAST  output  1  high with word M*N-1.

Function
REQ-016 SHALL implement two states: LOAD (output_ready=1) and SEND (output_ready=0).
REQ-017 In LOAD, SHALL write C_wr_data to C_wr_addr on each cycle with C_wr_en=1.
REQ-018 In SEND, SHALL ignore C_wr_en and compute_finished.
REQ-019 SHALL move LOAD->SEND on the edge that samples compute_finished=1; a simultaneous C_wr_en write in that cycle SHALL still be committed.
REQ-020 SHALL stream addresses 0..M*N-1 in ascending order, exactly once per SEND.
REQ-021 SHALL assert AXIS_TVALID no later than the 2nd edge after the edge that entered SEND (one-cycle memory read latency).
REQ-022 SHALL count a transfer only on an edge with AXIS_TVALID && AXIS_TREADY.
REQ-023 SHALL hold AXIS_TDATA, AXIS_TLAST stable and AXIS_TVALID high while AXIS_TVALID && !AXIS_TREADY.
REQ-024 SHALL sustain one transfer per cycle while AXIS_TREADY is held high (prefetch/skid register; no bubbles after the first word).
REQ-025 SHALL assert AXIS_TLAST only with the word at address M*N-1.
REQ-026 SHALL return SEND->LOAD on the edge completing the TLAST transfer, with AXIS_TVALID=0 and output_ready=1 after that edge.
REQ-027 SHALL never assert AXIS_TVALID in LOAD.
REQ-028 Read address counter SHALL saturate at M*N-1 (no wrap into address 0 within one SEND).
REQ-029 AXIS_TREADY toggling arbitrarily, including low on every other cycle, SHALL NOT drop, duplicate or reorder words.

Reset
REQ-030 On an edge with reset=0: state=LOAD, output_ready=1, AXIS_TVALID=0, AXIS_TLAST=0, AXIS_TDATA=0, read counter=0, prefetch register empty.
REQ-031 Reset mid-SEND SHALL abort the stream immediately (no TLAST emitted); buffer contents SHALL NOT be cleared.
REQ-032 C_wr_en and compute_finished SHALL be ignored on reset edges.

Structure
REQ-033 SHALL instantiate the team's existing single-port memory (WIDTH=OUTW, SIZE=M*N) as its only sub-module; address muxed between C_wr_addr (LOAD) and read counter (SEND).
REQ-034 The state enum (LOAD, SEND) SHALL live in the shared matmul package alongside the existing M, N, MAXK defaults.

Verification
REQ-035 Load 0..62 (value=addr) with M=7,N=9, pulse compute_finished, TREADY=1 -> 63 consecutive beats 0..62, TLAST on 62 only, output_ready=1 after.
REQ-036 Same load, TREADY pattern 1,0,1,0 -> same 63 values in order, TDATA stable during each TREADY=0 stall.
REQ-037 C_wr_en with addr 5, data 999 during SEND -> beat 5 still carries the originally loaded value.
REQ-038 reset=0 after beat 30 -> TVALID=0 next cycle, output_ready=1; fresh compute_finished streams from beat 0 with retained contents.
REQ-039 compute_finished in same cycle as write addr 62 = -1 -> beat 62 equals -1 (sign preserved at OUTW).
REQ-040 TREADY=0 for 20 cycles after entering SEND -> TVALID high, TDATA=word 0 throughout, no beat lost once TREADY rises.

Source files
------------

// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared matmul defaults and output buffer state type
package matmul_pkg;

  localparam int M    = 7;
  localparam int N    = 9;
  localparam int MAXK = 16;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_SEND = 1'b1
  } out_state_e;

endpackage

// File: rtl/output_mems_spram.sv
// rtl/output_mems_spram.sv - single-port memory with registered read
module output_mems_spram #(
  parameter  int WIDTH = 24,
  parameter  int SIZE  = 63,
  localparam int AW    = $clog2(SIZE)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [SIZE];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/output_mems.sv
// rtl/output_mems.sv - result buffer: loads compute writes, then streams them out
module output_mems #(
  parameter  int OUTW        = 24,
  parameter  int M           = matmul_pkg::M,
  parameter  int N           = matmul_pkg::N,
  localparam int C_ADDR_BITS = $clog2(M*N)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   C_wr_en,
  input  logic [C_ADDR_BITS-1:0] C_wr_addr,
  input  logic [OUTW-1:0]        C_wr_data,
  input  logic                   compute_finished,
  output logic                   output_ready,
  output logic [OUTW-1:0]        AXIS_TDATA,
  output logic                   AXIS_TVALID,
  input  logic                   AXIS_TREADY,
  output logic                   AXIS_TLAST
);

  import matmul_pkg::*;

  localparam int                     DEPTH     = M * N;
  localparam logic [C_ADDR_BITS-1:0] LAST_ADDR = C_ADDR_BITS'(DEPTH - 1);

  out_state_e             state_q, state_d;
  logic [C_ADDR_BITS-1:0] rd_cnt_q, rd_cnt_d;
  logic                   rd_done_q, rd_done_d;
  logic                   pend_q, pend_d, pend_last_q, pend_last_d;
  logic [OUTW-1:0]        out_data_q, out_data_d, skid_data_q, skid_data_d;
  logic                   out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic                   skid_valid_q, skid_valid_d, skid_last_q, skid_last_d;

  logic                   pop, issue, mem_we;
  logic [1:0]             occ;
  logic [C_ADDR_BITS-1:0] mem_addr;
  logic [OUTW-1:0]        mem_rdata;

  output_mems_spram #(.WIDTH(OUTW), .SIZE(DEPTH)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (C_wr_data),
    .rdata (mem_rdata)
  );

  always_comb begin
    pop      = out_valid_q && AXIS_TREADY;
    occ      = {1'b0, out_valid_q} + {1'b0, skid_valid_q} + {1'b0, pend_q};
    // Issue a read only if the word will have a slot (output or skid) when it lands.
    issue    = (state_q == ST_SEND) && !rd_done_q && ((occ - {1'b0, pop}) < 2'd2);
    mem_we   = (state_q == ST_LOAD) && C_wr_en && reset;
    mem_addr = (state_q == ST_SEND) ? rd_cnt_q : C_wr_addr;

    state_d      = state_q;
    rd_cnt_d     = rd_cnt_q;
    rd_done_d    = rd_done_q;
    pend_d       = issue;
    pend_last_d  = issue && (rd_cnt_q == LAST_ADDR);
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;
    skid_data_d  = skid_data_q;
    skid_valid_d = skid_valid_q;
    skid_last_d  = skid_last_q;

    if (issue) begin
      if (rd_cnt_q == LAST_ADDR) begin
        rd_done_d = 1'b1;
      end else begin
        rd_cnt_d = rd_cnt_q + C_ADDR_BITS'(1);
      end
    end

    if (pop || !out_valid_q) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        out_last_d   = skid_last_q;
        skid_valid_d = pend_q;
        skid_data_d  = pend_q ? mem_rdata : skid_data_q;
        skid_last_d  = pend_q && pend_last_q;
      end else if (pend_q) begin
        out_valid_d = 1'b1;
        out_data_d  = mem_rdata;
        out_last_d  = pend_last_q;
      end else begin
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end
    end else if (pend_q) begin
      skid_valid_d = 1'b1;
      skid_data_d  = mem_rdata;
      skid_last_d  = pend_last_q;
    end

    case (state_q)
      ST_LOAD: begin
        if (compute_finished) begin
          state_d   = ST_SEND;
          rd_cnt_d  = '0;
          rd_done_d = 1'b0;
        end
      end
      default: begin
        if (pop && out_last_q) begin
          state_d   = ST_LOAD;
          rd_cnt_d  = '0;
          rd_done_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_LOAD;
      rd_cnt_q     <= '0;
      rd_done_q    <= 1'b0;
      pend_q       <= 1'b0;
      pend_last_q  <= 1'b0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      skid_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_cnt_q     <= rd_cnt_d;
      rd_done_q    <= rd_done_d;
      pend_q       <= pend_d;
      pend_last_q  <= pend_last_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      skid_data_q  <= skid_data_d;
      skid_valid_q <= skid_valid_d;
      skid_last_q  <= skid_last_d;
    end
  end

  assign output_ready = (state_q == ST_LOAD);
  assign AXIS_TDATA   = out_data_q;
  assign AXIS_TVALID  = out_valid_q;
  assign AXIS_TLAST   = out_last_q;

endmodule

// File: tb/tb_output_mems.sv
// tb/tb_output_mems.sv - scoreboard bench for output_mems with randomized backpressure
module tb_output_mems;

  localparam int OUTW  = 24;
  localparam int M     = 7;
  localparam int N     = 9;
  localparam int DEPTH = M * N;
  localparam int AW    = $clog2(DEPTH);

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            C_wr_en = 1'b0;
  logic [AW-1:0]   C_wr_addr = '0;
  logic [OUTW-1:0] C_wr_data = '0;
  logic            compute_finished = 1'b0;
  logic            output_ready;
  logic [OUTW-1:0] AXIS_TDATA;
  logic            AXIS_TVALID;
  logic            AXIS_TREADY = 1'b0;
  logic            AXIS_TLAST;

  output_mems #(.OUTW(OUTW), .M(M), .N(N)) dut (
    .clk              (clk),
    .reset            (reset),
    .C_wr_en          (C_wr_en),
    .C_wr_addr        (C_wr_addr),
    .C_wr_data        (C_wr_data),
    .compute_finished (compute_finished),
    .output_ready     (output_ready),
    .AXIS_TDATA       (AXIS_TDATA),
    .AXIS_TVALID      (AXIS_TVALID),
    .AXIS_TREADY      (AXIS_TREADY),
    .AXIS_TLAST       (AXIS_TLAST)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // Reference model: what the buffer should hold, and the beats a stream should deliver.
  logic [OUTW-1:0] model_mem [DEPTH];
  logic [OUTW-1:0] exp_data [$];
  logic            exp_last [$];

  int              beats = 0;
  int              first_cyc = 0;
  int              last_cyc = 0;
  logic            stall_prev = 1'b0;
  logic [OUTW-1:0] stall_data = '0;
  logic            stall_last = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_all();
    for (int a = 0; a < DEPTH; a++) begin
      exp_data.push_back(model_mem[a]);
      exp_last.push_back(a == DEPTH - 1);
    end
  endtask

  // Monitor: transfers happen on the posedge following a negedge where valid&&ready.
  always @(negedge clk) begin
    if (reset) begin
      if (output_ready) chk("valid_in_load", AXIS_TVALID, 1'b0);
      if (stall_prev) begin
        chk("stall_valid", AXIS_TVALID, 1'b1);
        chk("stall_data", AXIS_TDATA, stall_data);
        chk("stall_last", AXIS_TLAST, stall_last);
      end
      if (AXIS_TVALID && AXIS_TREADY) begin
        if (exp_data.size() == 0) begin
          chk("unexpected_beat", AXIS_TDATA, 32'hdead);
        end else begin
          chk("beat_data", AXIS_TDATA, exp_data.pop_front());
          chk("beat_last", AXIS_TLAST, exp_last.pop_front());
        end
        if (beats == 0) first_cyc = cyc;
        last_cyc = cyc;
        beats++;
      end
      stall_prev = AXIS_TVALID && !AXIS_TREADY;
      stall_data = AXIS_TDATA;
      stall_last = AXIS_TLAST;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic load_buf(input int kind, input bit cf_last);
    chk("load_ready", output_ready, 1'b1);
    for (int a = 0; a < DEPTH; a++) begin
      logic [OUTW-1:0] v;
      v = (kind == 0) ? OUTW'(a) : OUTW'($urandom);
      if (kind == 2 && a == DEPTH - 1) v = '1;
      C_wr_en          = 1'b1;
      C_wr_addr        = AW'(a);
      C_wr_data        = v;
      compute_finished = cf_last && (a == DEPTH - 1);
      model_mem[a]     = v;
      @(posedge clk); #1;
    end
    C_wr_en          = 1'b0;
    compute_finished = 1'b0;
    if (cf_last) push_all();
  endtask

  task automatic pulse_cf();
    compute_finished = 1'b1;
    @(posedge clk); #1;
    compute_finished = 1'b0;
    push_all();
  endtask

  // mode: 0 ready high, 1 alternating, 2 random, 3 low for 20 cycles then high
  task automatic run_stream(input int mode, input int abort_at, input bit poke);
    bit done;
    done  = 1'b0;
    beats = 0;
    for (int k = 0; k < 3000 && !done; k++) begin
      if (k == 2) chk("first_valid_latency", AXIS_TVALID, 1'b1);
      if (mode == 3 && k >= 2 && k < 20 && exp_data.size() > 0) begin
        chk("hold_valid", AXIS_TVALID, 1'b1);
        chk("hold_word0", AXIS_TDATA, exp_data[0]);
      end
      if (abort_at > 0 && beats == abort_at) begin
        reset            = 1'b0;
        AXIS_TREADY      = 1'b1;
        C_wr_en          = 1'b1;
        C_wr_addr        = '0;
        C_wr_data        = 24'h012345;
        compute_finished = 1'b1;
        exp_data.delete();
        exp_last.delete();
        @(posedge clk); #1;
        reset            = 1'b1;
        C_wr_en          = 1'b0;
        compute_finished = 1'b0;
        AXIS_TREADY      = 1'b0;
        chk("abort_valid", AXIS_TVALID, 1'b0);
        chk("abort_ready", output_ready, 1'b1);
        chk("abort_last", AXIS_TLAST, 1'b0);
        return;
      end
      case (mode)
        0:       AXIS_TREADY = 1'b1;
        1:       AXIS_TREADY = (k % 2 == 0);
        2:       AXIS_TREADY = 1'($urandom_range(0, 1));
        default: AXIS_TREADY = (k >= 20);
      endcase
      if (poke && beats < 50) begin
        C_wr_en          = 1'b1;
        C_wr_addr        = AW'(5);
        C_wr_data        = OUTW'(999);
        compute_finished = 1'b1;
      end else begin
        C_wr_en          = 1'b0;
        compute_finished = 1'b0;
      end
      @(posedge clk); #1;
      if (output_ready) done = 1'b1;
    end
    C_wr_en          = 1'b0;
    compute_finished = 1'b0;
    AXIS_TREADY      = 1'b0;
    chk("stream_completed", done, 1'b1);
    chk("end_valid_low", AXIS_TVALID, 1'b0);
    chk("beat_count", beats, DEPTH);
    chk("queue_drained", exp_data.size(), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", output_ready, 1'b1);
    chk("rst_valid", AXIS_TVALID, 1'b0);
    chk("rst_last", AXIS_TLAST, 1'b0);
    chk("rst_data", AXIS_TDATA, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    load_buf(0, 1'b0);
    pulse_cf();
    run_stream(0, 0, 1'b0);
    chk("no_bubbles", last_cyc - first_cyc, DEPTH - 1);

    pulse_cf();
    run_stream(1, 0, 1'b0);

    pulse_cf();
    run_stream(2, 0, 1'b1);

    pulse_cf();
    run_stream(0, 31, 1'b0);
    pulse_cf();
    run_stream(2, 0, 1'b0);

    load_buf(2, 1'b1);
    run_stream(3, 0, 1'b0);

    for (int t = 0; t < 3; t++) begin
      load_buf(1, 1'($urandom_range(0, 1)));
      if (output_ready) pulse_cf();
      run_stream(2, 0, 1'b0);
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
